// File: rtl/mdio_phy_mgr_if.sv
// Command/response bundle between the PHY management sequencer and the MDIO master.
// The sequencer side is "master" because it issues commands and consumes read data.
interface mdio_phy_mgr_if;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;

  modport master (
    output cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode, cmd_valid, data_out_ready,
    input  cmd_ready, data_out, data_out_valid
  );

  modport slave (
    input  cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode, cmd_valid, data_out_ready,
    output cmd_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/mdio_phy_mgr.sv
// PHY management sequencer: soft-reset the PHY, restart autonegotiation, then
// periodically poll BMSR and the vendor status register and publish link state.
module mdio_phy_mgr #(
  parameter logic [4:0]  PHY_ADDR        = 5'd0,
  parameter logic [23:0] POLL_INTERVAL   = 24'd1000000,
  parameter logic [7:0]  MAX_RESET_POLLS = 8'd16,
  parameter logic [4:0]  STATUS_REG      = 5'h11,
  parameter logic [3:0]  SPEED_LSB       = 4'd14,
  parameter logic [3:0]  DUPLEX_BIT      = 4'd13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  mdio_phy_mgr_if.master        mif,
  output logic                  init_done,
  output logic                  init_error,
  output logic                  link_up,
  output logic [1:0]            speed,
  output logic                  full_duplex,
  output logic                  status_valid,
  output logic                  busy
);

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  typedef enum logic [3:0] {
    IDLE, RST_WR, RST_RD, RSP_RST, AN_WR, WAIT,
    BMSR_RD, RSP_BMSR, STS_RD, RSP_STS, ERROR
  } state_t;

  state_t      state;
  logic [23:0] interval_cnt;
  logic [7:0]  poll_cnt;
  logic        link_hold;
  logic        cmd_acc;
  logic        rsp_acc;
  logic        unused_rsp_bits;

  assign cmd_acc = mif.cmd_valid && mif.cmd_ready;
  assign rsp_acc = mif.data_out_valid && mif.data_out_ready;
  assign unused_rsp_bits = ^mif.data_out;

  // {reg_addr, data, opcode} for the command each command state issues
  function automatic logic [22:0] cmd_for(state_t s);
    case (s)
      RST_WR:  cmd_for = {5'd0, 16'h8000, OP_WR};
      RST_RD:  cmd_for = {5'd0, 16'h0000, OP_RD};
      AN_WR:   cmd_for = {5'd0, 16'h1200, OP_WR};
      BMSR_RD: cmd_for = {5'd1, 16'h0000, OP_RD};
      STS_RD:  cmd_for = {STATUS_REG, 16'h0000, OP_RD};
      default: cmd_for = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      interval_cnt       <= '0;
      poll_cnt           <= '0;
      link_hold          <= 1'b0;
      mif.cmd_phy_addr   <= '0;
      mif.cmd_reg_addr   <= '0;
      mif.cmd_data       <= '0;
      mif.cmd_opcode     <= '0;
      mif.cmd_valid      <= 1'b0;
      mif.data_out_ready <= 1'b0;
      init_done          <= 1'b0;
      init_error         <= 1'b0;
      link_up            <= 1'b0;
      speed              <= '0;
      full_duplex        <= 1'b0;
      status_valid       <= 1'b0;
      busy               <= 1'b0;
    end else begin
      mif.cmd_phy_addr <= PHY_ADDR;
      status_valid     <= 1'b0;
      if (cmd_acc) mif.cmd_valid <= 1'b0;
      if (rsp_acc) mif.data_out_ready <= 1'b0;

      // Command states raise cmd_valid once and then hold the fields until accepted;
      // a disable only takes effect once the transaction in flight has finished.
      case (state)
        IDLE: if (enable) begin
          state    <= RST_WR;
          busy     <= 1'b1;
          poll_cnt <= '0;
          {mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode, mif.cmd_valid} <= {cmd_for(RST_WR), 1'b1};
        end

        RST_WR, AN_WR: begin
          if (cmd_acc) begin
            if (!enable) begin
              state <= IDLE;
              {busy, init_done, link_up, speed, full_duplex} <= '0;
            end else if (state == RST_WR) begin
              state <= RST_RD;
            end else begin
              state        <= WAIT;
              init_done    <= 1'b1;
              interval_cnt <= POLL_INTERVAL;
            end
          end else if (!mif.cmd_valid) begin
            {mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode, mif.cmd_valid} <= {cmd_for(state), 1'b1};
          end
        end

        RST_RD, BMSR_RD, STS_RD: begin
          if (cmd_acc) begin
            mif.data_out_ready <= 1'b1;
            state <= (state == RST_RD) ? RSP_RST : (state == BMSR_RD) ? RSP_BMSR : RSP_STS;
          end else if (!mif.cmd_valid) begin
            {mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode, mif.cmd_valid} <= {cmd_for(state), 1'b1};
          end
        end

        RSP_RST: if (rsp_acc) begin
          if (!enable) begin
            state <= IDLE;
            {busy, init_done, link_up, speed, full_duplex} <= '0;
          end else if (!mif.data_out[15]) begin
            state <= AN_WR;
          end else if ({1'b0, poll_cnt} + 9'd1 >= {1'b0, MAX_RESET_POLLS}) begin
            state      <= ERROR;
            init_error <= 1'b1;
            poll_cnt   <= MAX_RESET_POLLS;
          end else begin
            state    <= RST_RD;
            poll_cnt <= poll_cnt + 8'd1;
          end
        end

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
            {busy, init_done, link_up, speed, full_duplex} <= '0;
          end else if (interval_cnt == 24'd0) begin
            state <= BMSR_RD;
            {mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode, mif.cmd_valid} <= {cmd_for(BMSR_RD), 1'b1};
          end else begin
            interval_cnt <= interval_cnt - 24'd1;
          end
        end

        RSP_BMSR: if (rsp_acc) begin
          if (!enable) begin
            state <= IDLE;
            {busy, init_done, link_up, speed, full_duplex} <= '0;
          end else begin
            link_hold <= mif.data_out[2];
            state     <= STS_RD;
          end
        end

        // Link, speed and duplex move together so consumers never see a half-updated round
        RSP_STS: if (rsp_acc) begin
          if (!enable) begin
            state <= IDLE;
            {busy, init_done, link_up, speed, full_duplex} <= '0;
          end else begin
            link_up      <= link_hold;
            speed        <= mif.data_out[SPEED_LSB +: 2];
            full_duplex  <= mif.data_out[DUPLEX_BIT];
            status_valid <= 1'b1;
            interval_cnt <= POLL_INTERVAL;
            state        <= WAIT;
          end
        end

        ERROR: if (!enable) begin
          state      <= IDLE;
          init_error <= 1'b0;
          busy       <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_mgr.sv
// Directed bench for mdio_phy_mgr: a scripted MDIO master/PHY model answers commands
// and the main sequence checks init, polling, stalls, reset and disable behaviour.
module tb_mdio_phy_mgr;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       init_done, init_error, link_up, full_duplex, status_valid, busy;
  logic [1:0] speed;

  mdio_phy_mgr_if mif();

  mdio_phy_mgr #(
    .PHY_ADDR      (5'h03),
    .POLL_INTERVAL (24'd10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mif          (mif),
    .init_done    (init_done),
    .init_error   (init_error),
    .link_up      (link_up),
    .speed        (speed),
    .full_duplex  (full_duplex),
    .status_valid (status_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] data;
    logic [1:0]  op;
    int          rise;
    logic        link_at;
  } cmd_t;

  cmd_t        log_q[$];
  logic [15:0] bmcr_script[$];
  logic [15:0] bmcr_default = 16'h0000;
  logic [15:0] bmsr_val     = 16'h796D;
  logic [15:0] sts_val      = 16'h6000;

  int checks = 0, errors = 0;
  int cyc = 0;
  int stall = 0, stall_cycles = 0, stall_err = 0;
  int rsp_delay = 0, hold_cycles = 0, rsp_drop = 0;
  int sv_count = 0, sv_cycle = 0, overlap_err = 0;
  int rise_cyc = 0, sv_mark = 0, log_mark = 0;
  logic        stall_ref_set = 1'b0;
  logic [27:0] stall_ref = '0;
  logic        rsp_pending = 1'b0, rsp_seen_ready = 1'b0, prev_valid = 1'b0;
  logic [4:0]  rsp_reg = '0;

  initial forever @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // MDIO master / PHY model, reacting on the falling edge so the DUT samples stable inputs
  initial begin
    mif.cmd_ready      = 1'b0;
    mif.data_out       = '0;
    mif.data_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mif.cmd_ready      = 1'b0;
        mif.data_out_valid = 1'b0;
        rsp_pending        = 1'b0;
        rsp_seen_ready     = 1'b0;
        stall_ref_set      = 1'b0;
        prev_valid         = 1'b0;
      end else begin
        mif.cmd_ready = 1'b0;
        if (status_valid) begin
          sv_count++;
          sv_cycle = cyc;
        end
        if (mif.data_out_valid) begin
          mif.data_out_valid = 1'b0;
          rsp_pending        = 1'b0;
          rsp_seen_ready     = 1'b0;
        end else if (rsp_pending) begin
          if (mif.data_out_ready) begin
            rsp_seen_ready = 1'b1;
            if (rsp_delay > 0) begin
              rsp_delay--;
              hold_cycles++;
            end else begin
              case (rsp_reg)
                5'd0:    mif.data_out = (bmcr_script.size() > 0) ? bmcr_script.pop_front() : bmcr_default;
                5'd1:    mif.data_out = bmsr_val;
                5'h11:   mif.data_out = sts_val;
                default: mif.data_out = 16'h0000;
              endcase
              mif.data_out_valid = 1'b1;
            end
          end else if (rsp_seen_ready) begin
            rsp_drop++;
          end
        end
        if (mif.cmd_valid) begin
          if (!prev_valid) rise_cyc = cyc;
          if (rsp_pending) overlap_err++;
          if (stall > 0) begin
            if (!stall_ref_set) begin
              stall_ref     = {mif.cmd_phy_addr, mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode};
              stall_ref_set = 1'b1;
            end else if ({mif.cmd_phy_addr, mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode} !== stall_ref) begin
              stall_err++;
            end
            stall--;
            stall_cycles++;
          end else begin
            if (stall_ref_set && {mif.cmd_phy_addr, mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode} !== stall_ref)
              stall_err++;
            stall_ref_set = 1'b0;
            mif.cmd_ready = 1'b1;
            log_q.push_back('{mif.cmd_phy_addr, mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode, rise_cyc, link_up});
            if (mif.cmd_opcode == 2'b10) begin
              rsp_pending    = 1'b1;
              rsp_seen_ready = 1'b0;
              rsp_reg        = mif.cmd_reg_addr;
            end
          end
        end else if (stall_ref_set) begin
          stall_err++;
        end
        prev_valid = mif.cmd_valid;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rn);
    enable = en;
    rst_n  = rn;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [37:0] outsVec();
    return {mif.cmd_phy_addr, mif.cmd_reg_addr, mif.cmd_data, mif.cmd_opcode, mif.cmd_valid,
            mif.data_out_ready, init_done, init_error, link_up, speed, full_duplex, status_valid, busy};
  endfunction

  function automatic bit condMet(input int sel);
    case (sel)
      0:       return init_done;
      1:       return sv_count > sv_mark;
      2:       return init_error;
      3:       return !busy;
      4:       return log_q.size() > log_mark;
      5:       return (log_q.size() > log_mark) && (log_q[$].rg == 5'h11);
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitUntil(input int sel, input int budget, input string tag);
    int n;
    bit hit;
    n   = 0;
    hit = condMet(sel);
    while (!hit && n < budget) begin
      stepCycle();
      n++;
      hit = condMet(sel);
    end
    checkOutput(tag, hit, 1);
  endtask

  task automatic checkEntry(input int idx, input string tag, input logic [4:0] rg,
                            input logic [15:0] d, input logic [1:0] op);
    logic [27:0] act;
    act = (idx < log_q.size()) ? {log_q[idx].phy, log_q[idx].rg, log_q[idx].data, log_q[idx].op} : '1;
    checkOutput(tag, act, {5'h03, rg, d, op});
  endtask

  function automatic int countBmcrReads(input int from);
    int n;
    n = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].op == 2'b10 && log_q[i].rg == 5'd0) n++;
    return n;
  endfunction

  initial begin
    int n;
    int busy_drops;
    int c0;
    int vcount;
    int idx;

    rst_n  = 1'b1;
    enable = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) stepCycle();
    checkOutput("reset_outs", outsVec(), 0);

    // Clean bring-up: BMCR reads back with reset already cleared
    bmcr_script.push_back(16'h0000);
    log_mark = 0;
    applyStimulus(1'b1, 1'b1);
    busy_drops = 0;
    n = 0;
    while (!init_done && n < 200) begin
      stepCycle();
      n++;
      if (!busy) busy_drops++;
    end
    checkOutput("init_done_t1", init_done, 1);
    checkOutput("busy_during_init", busy_drops, 0);
    checkOutput("cmd_count_t1", log_q.size(), 3);
    checkEntry(0, "t1_reset_write", 5'd0, 16'h8000, 2'b01);
    checkEntry(1, "t1_bmcr_read", 5'd0, 16'h0000, 2'b10);
    checkEntry(2, "t1_an_write", 5'd0, 16'h1200, 2'b01);
    checkOutput("phy_addr_t1", mif.cmd_phy_addr, 5'h03);

    // First status round: BMSR 0x796D, status 0x6000 -> link, 100M, full duplex
    sv_mark = sv_count;
    waitUntil(1, 100, "pulse_r1");
    checkOutput("link_r1", link_up, 1);
    checkOutput("speed_r1", speed, 2'b01);
    checkOutput("duplex_r1", full_duplex, 1);
    c0 = sv_cycle;
    stall     = 20;
    rsp_delay = 50;
    bmsr_val  = 16'h7969;
    sts_val   = 16'h8000;
    log_mark  = log_q.size();
    stepCycle();
    checkOutput("pulse_width_r1", status_valid, 0);

    // Second round with a stalled command and a late response
    sv_mark = sv_count;
    waitUntil(1, 300, "pulse_r2");
    idx = log_mark;
    checkEntry(idx, "r2_bmsr_cmd", 5'd1, 16'h0000, 2'b10);
    checkOutput("poll_interval", (idx < log_q.size()) ? log_q[idx].rise - c0 : -1, 11);
    checkOutput("stall_cycles", stall_cycles, 20);
    checkOutput("stall_stable", stall_err, 0);
    checkOutput("rsp_hold_cycles", hold_cycles, 50);
    checkOutput("rsp_ready_held", rsp_drop, 0);
    checkEntry(idx + 1, "r2_sts_cmd", 5'h11, 16'h0000, 2'b10);
    checkOutput("link_stable_mid_round", (idx + 1 < log_q.size()) ? log_q[idx + 1].link_at : 1'b0, 1);
    checkOutput("link_r2", link_up, 0);
    checkOutput("speed_r2", speed, 2'b10);
    checkOutput("duplex_r2", full_duplex, 0);

    // Reset while the status read response is outstanding
    log_mark = log_q.size();
    waitUntil(5, 100, "sts_cmd_r3");
    rsp_delay = 40;
    repeat (5) stepCycle();
    checkOutput("ready_waiting_r3", mif.data_out_ready, 1);
    bmcr_default = 16'h8000;
    rsp_delay    = 0;
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("async_reset_outs", outsVec(), 0);
    stepCycle();
    applyStimulus(1'b1, 1'b1);
    log_mark = log_q.size();
    waitUntil(4, 50, "restart_cmd");
    checkEntry(log_mark, "restart_reset_write", 5'd0, 16'h8000, 2'b01);

    // BMCR reset bit never clears -> error after the poll budget
    waitUntil(2, 800, "init_error_set");
    checkOutput("bmcr_reads_err", countBmcrReads(log_mark), 16);
    checkOutput("init_done_err", init_done, 0);
    vcount = 0;
    repeat (20) begin
      stepCycle();
      if (mif.cmd_valid) vcount++;
    end
    checkOutput("no_cmd_in_error", vcount, 0);
    checkOutput("error_held", init_error, 1);
    checkOutput("busy_in_error", busy, 1);
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("error_cleared", init_error, 0);
    checkOutput("idle_after_error", busy, 0);

    // Reset bit clears on the fourth BMCR read
    bmcr_default = 16'h0000;
    bmcr_script.push_back(16'h8000);
    bmcr_script.push_back(16'h8000);
    bmcr_script.push_back(16'h8000);
    bmcr_script.push_back(16'h1140);
    bmsr_val = 16'h796D;
    sts_val  = 16'h6000;
    log_mark = log_q.size();
    stepCycle();
    applyStimulus(1'b1, 1'b1);
    waitUntil(0, 300, "init_done_t2");
    checkOutput("bmcr_reads_t2", countBmcrReads(log_mark), 4);
    checkOutput("init_error_t2", init_error, 0);
    checkEntry(log_q.size() - 1, "t2_an_write", 5'd0, 16'h1200, 2'b01);

    // Disable while the status response is pending: transaction drains, no update
    sv_mark = sv_count;
    waitUntil(1, 100, "pulse_t2");
    checkOutput("link_t2", link_up, 1);
    log_mark = log_q.size();
    waitUntil(5, 100, "sts_cmd_t2");
    rsp_delay = 20;
    sts_val   = 16'h0000;
    repeat (3) stepCycle();
    applyStimulus(1'b0, 1'b1);
    sv_mark = sv_count;
    waitUntil(3, 100, "idle_after_disable");
    checkOutput("no_pulse_on_disable", sv_count, sv_mark);
    checkOutput("rsp_consumed", rsp_pending, 0);
    checkOutput("link_cleared", link_up, 0);
    checkOutput("init_done_cleared", init_done, 0);
    checkOutput("speed_cleared", speed, 2'b00);
    checkOutput("no_cmd_overlap", overlap_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
